// File: rtl/mem_lsu_stage.sv
// MEM->WB stage of the RV32 core: sub-word load/store lanes, posted store buffer with
// load forwarding, single-port cache sequencer. Define MEM_PERF_CNT_EN for perf counters.
module mem_lsu_stage #(
  parameter int SB_DEPTH = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic             rw_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      alu_i,
  input  logic [31:0]      pc4_i,
  input  logic [31:0]      inst_i,
  input  logic [1:0]       WBSel_i,
  input  logic             RegWEn_i,
  input  logic [4:0]       rsW_i,
  input  logic             enable_i,
  input  logic             flush_i,
  output logic             req_valid_o,
  output logic             req_rw_o,
  output logic [31:0]      req_addr_o,
  output logic [31:0]      req_wdata_o,
  output logic [3:0]       req_be_o,
  input  logic             rsp_ready_i,
  input  logic [31:0]      rsp_rdata_i,
  output logic             stall_o,
  output logic             misalign_o,
  output logic             sb_empty_o,
  output logic [31:0]      alu_wb_o,
  output logic [31:0]      pc4_wb_o,
  output logic [31:0]      mem_wb_o,
  output logic [31:0]      inst_wb_o,
  output logic [1:0]       WBSel_wb_o,
  output logic             RegWEn_wb_o,
  output logic [4:0]       rsW_wb_o,
  output logic [1:0]       dbg_state_o
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] no_load_o,
  output logic [CNT_W-1:0] no_store_o,
  output logic [CNT_W-1:0] no_fwd_o,
  output logic [CNT_W-1:0] no_stall_o
`endif
);

  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LD_WAIT = 2'd1,
    S_ST_WAIT = 2'd2
  } state_t;

  // Cache handshake: req_* is presented while req_valid_o=1 and held unchanged until the
  // cycle rsp_ready_i=1, which completes it (read data on rsp_rdata_i in that same cycle).

  logic [1:0]  a_lo;
  logic        misalign_c;
  logic        is_load;
  logic        is_store;
  logic [3:0]  acc_be;
  logic [31:0] st_lane;

  assign a_lo = addr_i[1:0];

  always_comb begin
    acc_be     = 4'b1111;
    st_lane    = wdata_i;
    misalign_c = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        acc_be  = 4'b0001 << a_lo;
        st_lane = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        acc_be     = 4'b0011 << a_lo;
        st_lane    = {2{wdata_i[15:0]}};
        misalign_c = a_lo[0];
      end
      default: misalign_c = (a_lo != 2'b00);
    endcase
  end

  assign misalign_o = valid_i & misalign_c;
  assign is_load    = valid_i & ~rw_i & ~misalign_c;
  assign is_store   = valid_i & rw_i & ~misalign_c;

  // Store buffer storage
  logic [29:0]         sb_addr [SB_DEPTH];
  logic [3:0]          sb_be   [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PTR_W:0]      wr_ptr, rd_ptr;
  logic [PTR_W-1:0]    head, tail;
  logic                sb_full, sb_empty;
  logic                push, pop;

  assign head     = rd_ptr[PTR_W-1:0];
  assign tail     = wr_ptr[PTR_W-1:0];
  assign sb_empty = (wr_ptr == rd_ptr);
  assign sb_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (head == tail);
  assign push     = is_store & (~sb_full | pop);
  assign sb_empty_o = sb_empty;

  // Oldest-to-youngest scan, so the last hit is the youngest matching entry.
  logic             fwd_match;
  logic [PTR_W-1:0] fwd_idx;
  logic [PTR_W-1:0] scan_idx;
  logic             fwd_cover;
  logic             fwd_hit;
  logic             ld_miss;

  always_comb begin
    fwd_match = 1'b0;
    fwd_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      scan_idx = head + PTR_W'(k);
      if (sb_vld[scan_idx] && (sb_addr[scan_idx] == addr_i[31:2])) begin
        fwd_match = 1'b1;
        fwd_idx   = scan_idx;
      end
    end
  end

  assign fwd_cover = ((sb_be[fwd_idx] & acc_be) == acc_be);
  assign fwd_hit   = is_load & fwd_match & fwd_cover;
  assign ld_miss   = is_load & ~fwd_match;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      sb_vld <= '0;
    end else begin
      if (pop) begin
        sb_vld[head] <= 1'b0;
        rd_ptr       <= rd_ptr + (PTR_W+1)'(1);
      end
      // A same-cycle push into the slot being popped (full buffer) must win.
      if (push) begin
        sb_vld[tail] <= 1'b1;
        wr_ptr       <= wr_ptr + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      sb_addr[tail] <= addr_i[31:2];
      sb_be[tail]   <= acc_be;
      sb_data[tail] <= st_lane;
    end
  end

  // Cache sequencer
  state_t      state_q, state_d;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_be_q;
  logic        ld_rsp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ld_miss) begin
          if (!rsp_ready_i) state_d = S_LD_WAIT;
        end else if (!sb_empty && !rsp_ready_i) begin
          state_d = S_ST_WAIT;
        end
      end
      S_LD_WAIT, S_ST_WAIT: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid_o = 1'b0;
    req_rw_o    = 1'b0;
    req_addr_o  = '0;
    req_wdata_o = '0;
    req_be_o    = '0;
    pop         = 1'b0;
    ld_rsp      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld_miss) begin
          req_valid_o = 1'b1;
          req_addr_o  = {addr_i[31:2], 2'b00};
          req_be_o    = acc_be;
          ld_rsp      = rsp_ready_i;
        end else if (!sb_empty) begin
          req_valid_o = 1'b1;
          req_rw_o    = 1'b1;
          req_addr_o  = {sb_addr[head], 2'b00};
          req_wdata_o = sb_data[head];
          req_be_o    = sb_be[head];
          pop         = rsp_ready_i;
        end
      end
      S_LD_WAIT: begin
        req_valid_o = 1'b1;
        req_addr_o  = req_addr_q;
        req_be_o    = req_be_q;
        ld_rsp      = rsp_ready_i;
      end
      S_ST_WAIT: begin
        req_valid_o = 1'b1;
        req_rw_o    = 1'b1;
        req_addr_o  = req_addr_q;
        req_wdata_o = req_wdata_q;
        req_be_o    = req_be_q;
        pop         = rsp_ready_i;
      end
      default: ;
    endcase
  end

  // Freeze the request issued from IDLE so it cannot drift while waiting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
    end else if (state_q == S_IDLE && req_valid_o && !rsp_ready_i) begin
      req_addr_q  <= req_addr_o;
      req_wdata_q <= req_wdata_o;
      req_be_q    <= req_be_o;
    end
  end

  assign dbg_state_o = state_q;

  // Completion, stall and load alignment
  logic        load_done;
  logic        op_done;
  logic [31:0] ld_word;
  logic [31:0] ld_shift;
  logic [31:0] ld_ext;
  logic [31:0] mem_res;

  assign load_done = is_load & (fwd_hit | ld_rsp);
  assign op_done   = rw_i ? push : load_done;
  assign stall_o   = valid_i & ~misalign_c & ~op_done;

  assign ld_word  = fwd_hit ? sb_data[fwd_idx] : rsp_rdata_i;
  assign ld_shift = ld_word >> {a_lo, 3'b000};

  always_comb begin
    case (funct3_i)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  assign mem_res = load_done ? ld_ext : 32'h0;

  // MEM->WB register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_wb_o    <= '0;
      pc4_wb_o    <= '0;
      mem_wb_o    <= '0;
      inst_wb_o   <= '0;
      WBSel_wb_o  <= '0;
      RegWEn_wb_o <= 1'b0;
      rsW_wb_o    <= '0;
    end else if (enable_i) begin
      if (flush_i) begin
        alu_wb_o    <= '0;
        pc4_wb_o    <= '0;
        mem_wb_o    <= '0;
        inst_wb_o   <= '0;
        WBSel_wb_o  <= '0;
        RegWEn_wb_o <= 1'b0;
        rsW_wb_o    <= '0;
      end else begin
        alu_wb_o    <= alu_i;
        pc4_wb_o    <= pc4_i;
        mem_wb_o    <= mem_res;
        inst_wb_o   <= inst_i;
        WBSel_wb_o  <= WBSel_i;
        RegWEn_wb_o <= RegWEn_i;
        rsW_wb_o    <= rsW_i;
      end
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      no_load_o  <= '0;
      no_store_o <= '0;
      no_fwd_o   <= '0;
      no_stall_o <= '0;
    end else begin
      if (load_done) no_load_o  <= no_load_o + CNT_W'(1);
      if (push)      no_store_o <= no_store_o + CNT_W'(1);
      if (fwd_hit)   no_fwd_o   <= no_fwd_o + CNT_W'(1);
      if (stall_o)   no_stall_o <= no_stall_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: forwarding, drain ordering, lane extraction,
// misalignment, buffer-full backpressure, WB register control and mid-transaction reset.
module tb_mem_lsu_stage;

  logic        clk;
  logic        rst_ni;
  logic        valid_i, rw_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i, alu_i, pc4_i, inst_i;
  logic [1:0]  WBSel_i;
  logic        RegWEn_i;
  logic [4:0]  rsW_i;
  logic        enable_i, flush_i;
  logic        req_valid_o, req_rw_o;
  logic [31:0] req_addr_o, req_wdata_o;
  logic [3:0]  req_be_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_i;
  logic        stall_o, misalign_o, sb_empty_o;
  logic [31:0] alu_wb_o, pc4_wb_o, mem_wb_o, inst_wb_o;
  logic [1:0]  WBSel_wb_o;
  logic        RegWEn_wb_o;
  logic [4:0]  rsW_wb_o;
  logic [1:0]  dbg_state_o;
`ifdef MEM_PERF_CNT_EN
  logic [31:0] no_load_o, no_store_o, no_fwd_o, no_stall_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  mem_lsu_stage #(.SB_DEPTH(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .rw_i(rw_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .alu_i(alu_i), .pc4_i(pc4_i), .inst_i(inst_i),
    .WBSel_i(WBSel_i), .RegWEn_i(RegWEn_i), .rsW_i(rsW_i), .enable_i(enable_i),
    .flush_i(flush_i), .req_valid_o(req_valid_o), .req_rw_o(req_rw_o),
    .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o), .req_be_o(req_be_o),
    .rsp_ready_i(rsp_ready_i), .rsp_rdata_i(rsp_rdata_i), .stall_o(stall_o),
    .misalign_o(misalign_o), .sb_empty_o(sb_empty_o), .alu_wb_o(alu_wb_o),
    .pc4_wb_o(pc4_wb_o), .mem_wb_o(mem_wb_o), .inst_wb_o(inst_wb_o),
    .WBSel_wb_o(WBSel_wb_o), .RegWEn_wb_o(RegWEn_wb_o), .rsW_wb_o(rsW_wb_o),
    .dbg_state_o(dbg_state_o)
`ifdef MEM_PERF_CNT_EN
    , .no_load_o(no_load_o), .no_store_o(no_store_o), .no_fwd_o(no_fwd_o),
    .no_stall_o(no_stall_o)
`endif
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Checkers
  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wb_check(input string tag);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL %s observed=%08h expected=<empty queue>", tag, mem_wb_o);
    end else begin
      e = exp_q.pop_front();
      n_checks--;
      chk32(tag, mem_wb_o, e);
    end
  endtask

  // Driver: apply one cycle of MEM inputs at the falling edge, settle, return.
  task automatic drive(input logic v, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    valid_i = v; rw_i = rw; funct3_i = f3; addr_i = a; wdata_i = wd;
    rsp_ready_i = rdy; rsp_rdata_i = rdata;
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    valid_i = 0; rw_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    alu_i = 0; pc4_i = 0; inst_i = 0; WBSel_i = 0; RegWEn_i = 0; rsW_i = 0;
    enable_i = 0; flush_i = 0; rsp_ready_i = 0; rsp_rdata_i = 0;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_req_valid", req_valid_o, 1'b0);
    chk1("rst_sb_empty", sb_empty_o, 1'b1);
    chk1("rst_stall", stall_o, 1'b0);
    chk32("rst_mem_wb", mem_wb_o, 32'h0);
    chk32("rst_state", {30'b0, dbg_state_o}, 32'h0);
    rst_ni = 1'b1;
    alu_i = 32'hA1A1_A1A1; pc4_i = 32'h0000_1004; inst_i = 32'h0001_2083;
    WBSel_i = 2'b01; RegWEn_i = 1'b1; rsW_i = 5'd3; enable_i = 1'b1;

    // SW then LW same word: forwarded, drain is a write, never a read
    drive(1, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0);
    chk1("sw_stall", stall_o, 1'b0);
    chk1("sw_req_valid", req_valid_o, 1'b0);
    drive(1, 0, 3'b010, 32'h100, 32'h0, 1, 32'h0BAD0BAD);
    chk1("lw_fwd_stall", stall_o, 1'b0);
    chk1("lw_fwd_req_rw", req_rw_o, 1'b1);
    chk32("lw_fwd_req_be", {28'b0, req_be_o}, 32'hF);
    exp_q.push_back(32'hDEADBEEF);

    // SB @0x101 then LH @0x100: partial cover stalls until drained
    drive(1, 1, 3'b000, 32'h101, 32'h0000007F, 1, 32'h0);
    wb_check("lw_fwd_data");
    chk32("pass_alu", alu_wb_o, 32'hA1A1_A1A1);
    chk32("pass_pc4", pc4_wb_o, 32'h0000_1004);
    chk32("pass_inst", inst_wb_o, 32'h0001_2083);
    chk32("pass_ctl", {25'b0, WBSel_wb_o, RegWEn_wb_o, rsW_wb_o}, {25'b0, 2'b01, 1'b1, 5'd3});
    chk1("sb_empty_after_drain", sb_empty_o, 1'b1);
    chk1("sb_stall", stall_o, 1'b0);
    drive(1, 0, 3'b001, 32'h100, 32'h0, 1, 32'h1234_5678);
    chk1("lh_block_stall", stall_o, 1'b1);
    chk1("lh_block_req_rw", req_rw_o, 1'b1);
    chk32("lh_block_req_be", {28'b0, req_be_o}, 32'h2);
    chk32("lh_block_req_wdata", req_wdata_o, 32'h7F7F_7F7F);
    chk32("lh_block_req_addr", req_addr_o, 32'h100);
    drive(1, 0, 3'b001, 32'h100, 32'h0, 1, 32'h1234_5678);
    chk1("lh_miss_stall", stall_o, 1'b0);
    chk1("lh_miss_req_rw", req_rw_o, 1'b0);
    chk32("lh_miss_req_addr", req_addr_o, 32'h100);
    exp_q.push_back(32'h0000_5678);

    // Lane extraction from cache word 0x80FF0000 @0x200
    drive(1, 0, 3'b000, 32'h202, 32'h0, 1, 32'h80FF_0000);
    wb_check("lh_cache_data");
    chk32("lb_req_be", {28'b0, req_be_o}, 32'h4);
    chk32("lb_req_addr", req_addr_o, 32'h200);
    exp_q.push_back(32'hFFFF_FFFF);
    drive(1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h80FF_0000);
    wb_check("lb_data");
    exp_q.push_back(32'h0000_0080);
    drive(1, 0, 3'b001, 32'h202, 32'h0, 1, 32'h80FF_0000);
    wb_check("lbu_data");
    exp_q.push_back(32'hFFFF_80FF);

    // Load miss with a two-cycle wait
    drive(1, 0, 3'b010, 32'h204, 32'h0, 0, 32'h0);
    wb_check("lh_neg_data");
    chk1("ldw_issue_stall", stall_o, 1'b1);
    chk32("ldw_issue_addr", req_addr_o, 32'h204);
    drive(1, 0, 3'b010, 32'h204, 32'h0, 0, 32'h0);
    chk1("ldw_wait_stall", stall_o, 1'b1);
    chk32("ldw_wait_state", {30'b0, dbg_state_o}, 32'h1);
    chk32("ldw_wait_addr", req_addr_o, 32'h204);
    drive(1, 0, 3'b010, 32'h204, 32'h0, 1, 32'hCAFE_F00D);
    chk1("ldw_done_stall", stall_o, 1'b0);
    exp_q.push_back(32'hCAFE_F00D);

    // Misaligned accesses
    drive(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h1111_1111);
    wb_check("ldw_data");
    chk1("mis_lw_flag", misalign_o, 1'b1);
    chk1("mis_lw_req_valid", req_valid_o, 1'b0);
    chk1("mis_lw_stall", stall_o, 1'b0);
    exp_q.push_back(32'h0);
    drive(1, 0, 3'b001, 32'h103, 32'h0, 1, 32'h1111_1111);
    wb_check("mis_lw_data");
    chk1("mis_lh_flag", misalign_o, 1'b1);
    drive(1, 1, 3'b010, 32'h106, 32'h55, 1, 32'h0);
    chk1("mis_sw_flag", misalign_o, 1'b1);
    chk1("mis_sw_stall", stall_o, 1'b0);
    drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 32'h0);
    chk1("mis_sw_not_buffered", sb_empty_o, 1'b1);
    chk1("mis_sw_no_req", req_valid_o, 1'b0);

    // WB register hold and flush
    enable_i = 1'b0; alu_i = 32'h2222_2222;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 32'h0);
    chk32("wb_hold_alu", alu_wb_o, 32'hA1A1_A1A1);
    enable_i = 1'b1; flush_i = 1'b1;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 32'h0);
    chk32("wb_flush_alu", alu_wb_o, 32'h0);
    chk32("wb_flush_pc4", pc4_wb_o, 32'h0);
    chk1("wb_flush_regwen", RegWEn_wb_o, 1'b0);
    flush_i = 1'b0;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 32'h0);
    chk32("wb_capture_alu", alu_wb_o, 32'h2222_2222);

    // Fill the buffer with the cache stalled
    drive(1, 1, 3'b000, 32'h400, 32'h11, 0, 32'h0);
    chk1("fill1_stall", stall_o, 1'b0);
    chk1("fill1_req_valid", req_valid_o, 1'b0);
    drive(1, 1, 3'b000, 32'h401, 32'h22, 0, 32'h0);
    chk1("fill2_stall", stall_o, 1'b0);
    chk1("fill2_req_rw", req_rw_o, 1'b1);
    chk32("fill2_req_be", {28'b0, req_be_o}, 32'h1);
    chk32("fill2_req_wdata", req_wdata_o, 32'h1111_1111);
    drive(1, 1, 3'b000, 32'h402, 32'h33, 0, 32'h0);
    chk1("fill3_stall", stall_o, 1'b0);
    chk32("fill3_state", {30'b0, dbg_state_o}, 32'h2);
    chk32("fill3_req_wdata_stable", req_wdata_o, 32'h1111_1111);
    chk32("fill3_req_addr_stable", req_addr_o, 32'h400);
    drive(1, 1, 3'b000, 32'h403, 32'h44, 0, 32'h0);
    chk1("fill4_stall", stall_o, 1'b0);
    drive(1, 1, 3'b010, 32'h404, 32'h5566_7788, 0, 32'h0);
    chk1("fill5_full_stall", stall_o, 1'b1);
    drive(1, 1, 3'b010, 32'h404, 32'h5566_7788, 1, 32'h0);
    chk1("fill5_pushpop_stall", stall_o, 1'b0);
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
    chk1("fill5_sb_not_empty", sb_empty_o, 1'b0);
    chk32("drain_state_idle", {30'b0, dbg_state_o}, 32'h0);
    chk32("drain_order_be", {28'b0, req_be_o}, 32'h2);
    chk32("drain_order_wdata", req_wdata_o, 32'h2222_2222);
    drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 32'h0);
    chk32("drain_wait_state", {30'b0, dbg_state_o}, 32'h2);
    drive(0, 0, 3'b000, 32'h0, 32'h0, 1, 32'h0);
    chk32("drain_next_be", {28'b0, req_be_o}, 32'h4);

    // Reach LD_WAIT with two buffered stores, then reset
    drive(1, 0, 3'b010, 32'h800, 32'h0, 0, 32'h0);
    chk1("ldw2_stall", stall_o, 1'b1);
    chk1("ldw2_req_rw", req_rw_o, 1'b0);
    chk32("ldw2_req_addr", req_addr_o, 32'h800);
    drive(1, 0, 3'b010, 32'h800, 32'h0, 0, 32'h0);
    chk32("ldw2_state", {30'b0, dbg_state_o}, 32'h1);
    chk1("ldw2_sb_not_empty", sb_empty_o, 1'b0);
    rst_ni = 1'b0;
    valid_i = 1'b0;
    #1;
    chk1("midrst_req_valid", req_valid_o, 1'b0);
    chk1("midrst_sb_empty", sb_empty_o, 1'b1);
    chk32("midrst_alu_wb", alu_wb_o, 32'h0);
    chk32("midrst_state", {30'b0, dbg_state_o}, 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
    drive(0, 0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
    chk1("postrst_req_valid", req_valid_o, 1'b0);
    chk1("postrst_sb_empty", sb_empty_o, 1'b1);
    chk32("postrst_state", {30'b0, dbg_state_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
